// File: rtl/countdown_timer_8bit_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.
package timer_pkg;

    localparam int unsigned TIMER_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/countdown_timer_8bit_if.sv
// Control/status bundle between the countdown timer and its user.
interface countdown_timer_8bit_if
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH
);
    logic             Load;
    logic [WIDTH-1:0] Data;
    logic             Enable;
    logic             Reload;
    logic [WIDTH-1:0] Q;
    logic             Busy;
    logic             Done;
    logic             Expired;

    modport master (
        output Load, Data, Enable, Reload,
        input  Q, Busy, Done, Expired
    );

    modport slave (
        input  Load, Data, Enable, Reload,
        output Q, Busy, Done, Expired
    );
endinterface

// File: rtl/countdown_timer_8bit_tff.sv
// T flip-flop with synchronous clear and parallel load; clear beats load beats toggle.
module t_flip_flop (
    input  logic Clock,
    input  logic Clear,
    input  logic Load,
    input  logic D,
    input  logic T,
    output logic Q
);
    logic r_q;

    always_ff @(posedge Clock) begin
        if (Clear)
            r_q <= 1'b0;
        else if (Load)
            r_q <= D;
        else if (T)
            r_q <= ~r_q;
    end

    assign Q = r_q;
endmodule

// File: rtl/countdown_timer_8bit.sv
// Loadable down counter built from T flip-flops, with expiry pulse and optional auto-reload.
module countdown_timer_8bit
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH
)(
    input  logic                    Clock,
    input  logic                    Clear,
    countdown_timer_8bit_if.slave   bus
);
    timer_state_t     r_state;
    logic [WIDTH-1:0] r_reload;
    logic             r_busy;
    logic             r_done;
    logic             r_expired;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_d;
    logic             w_count_en;
    logic             w_tc;
    logic             w_reload_now;
    logic             w_ld;

    // Load has priority, so it masks counting on the same edge.
    assign w_count_en   = (r_state == ST_RUN) && bus.Enable && !bus.Load;
    assign w_tc         = (w_q == WIDTH'(1));
    assign w_reload_now = w_count_en && w_tc && bus.Reload;
    assign w_ld         = bus.Load || w_reload_now;
    assign w_d          = bus.Load ? bus.Data : r_reload;

    // Bit i toggles when counting and every lower bit is zero (borrow ripple).
    always_comb begin
        w_t    = '0;
        w_t[0] = w_count_en;
        for (int unsigned i = 1; i < WIDTH; i++)
            w_t[i] = w_t[i-1] && !w_q[i-1];
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        t_flip_flop u_tff (
            .Clock (Clock),
            .Clear (Clear),
            .Load  (w_ld),
            .D     (w_d[g]),
            .T     (w_t[g]),
            .Q     (w_q[g])
        );
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state   <= ST_IDLE;
            r_reload  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else if (bus.Load) begin
            r_reload  <= bus.Data;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
            if (bus.Data != '0) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
            end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (bus.Enable && w_tc) begin
                        r_done <= 1'b1;
                        if (!bus.Reload) begin
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_expired <= 1'b1;
                        end
                    end
                end
                ST_DONE: r_expired <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.Q       = w_q;
    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;
    assign bus.Expired = r_expired;
endmodule

// File: tb/tb_countdown_timer_8bit.sv
// Self-checking bench: behavioural reference model compared every cycle, plus directed literal checks.
module tb_countdown_timer_8bit;
    logic clk;
    logic clr;
    int   n_cmp;
    int   n_bad;
    bit   chk_on;

    countdown_timer_8bit_if #(.WIDTH(8)) bus ();

    countdown_timer_8bit #(.WIDTH(8)) u_dut (
        .Clock (clk),
        .Clear (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 = idle, 1 = running, 2 = expired.
    logic [7:0] m_q, m_rel;
    int         m_st;
    logic       m_done;

    always @(posedge clk) begin
        if (clr) begin
            m_q = 8'd0; m_rel = 8'd0; m_st = 0; m_done = 1'b0;
        end else if (bus.Load) begin
            m_q = bus.Data; m_rel = bus.Data; m_done = 1'b0;
            m_st = (bus.Data != 8'd0) ? 1 : 0;
        end else if (m_st == 1 && bus.Enable) begin
            if (m_q == 8'd1) begin
                m_done = 1'b1;
                if (bus.Reload) m_q = m_rel;
                else begin m_q = 8'd0; m_st = 2; end
            end else begin
                m_q = m_q - 8'd1;
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_cmp++;
            if (bus.Q !== m_q || bus.Busy !== (m_st == 1) || bus.Done !== m_done
                || bus.Expired !== (m_st == 2)) begin
                n_bad++;
                $display("FAIL model t=%0t: Q=%0d B=%b D=%b E=%b, required Q=%0d B=%b D=%b E=%b",
                         $time, bus.Q, bus.Busy, bus.Done, bus.Expired,
                         m_q, (m_st == 1), m_done, (m_st == 2));
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [7:0] d, input logic en, input logic rl);
        bus.Load = ld; bus.Data = d; bus.Enable = en; bus.Reload = rl;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; chk_on = 0;
        clr = 1'b1;
        drive(1'b1, 8'd9, 1'b1, 1'b0);
        tick();
        chk_on = 1;
        drive(1'b0, 8'd9, 1'b0, 1'b0);
        tick();
        chk("reset_q", int'(bus.Q), 0);
        chk("reset_flags", int'({bus.Busy, bus.Done, bus.Expired}), 0);
        clr = 1'b0;

        // One-shot from 5
        drive(1'b1, 8'd5, 1'b1, 1'b0);
        tick();
        chk("oneshot_load", int'(bus.Q), 5);
        bus.Load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("oneshot_q", int'(bus.Q), 5 - k);
            chk("oneshot_done", int'(bus.Done), (k == 5) ? 1 : 0);
        end
        chk("oneshot_busy_fall", int'(bus.Busy), 0);
        for (int k = 0; k < 10; k++) tick();
        chk("oneshot_hold", int'({bus.Q, bus.Expired, bus.Busy, bus.Done}), 4);

        // Pause
        drive(1'b1, 8'd8, 1'b1, 1'b0);
        tick();
        bus.Load = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("pause_q", int'(bus.Q), 5);
        bus.Enable = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("pause_hold", int'(bus.Q), 5);
        chk("pause_busy", int'(bus.Busy), 1);
        bus.Enable = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("pause_nodone", int'(bus.Done), 0);
        tick();
        chk("pause_done", int'(bus.Done), 1);

        // Auto-reload of 3
        drive(1'b1, 8'd3, 1'b1, 1'b1);
        tick();
        bus.Load = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("reload_q", int'(bus.Q), 3 - ((k - 1) % 3 + 1) % 3 + (((k % 3) == 0) ? 0 : 0));
            chk("reload_done", int'(bus.Done), (k % 3 == 0) ? 1 : 0);
            chk("reload_busy", int'(bus.Busy), 1);
        end

        // Load 0
        drive(1'b1, 8'd0, 1'b1, 1'b0);
        tick();
        bus.Load = 1'b0;
        tick(); tick();
        chk("load0", int'({bus.Q, bus.Busy, bus.Done, bus.Expired}), 0);

        // Load 255
        drive(1'b1, 8'd255, 1'b1, 1'b0);
        tick();
        bus.Load = 1'b0;
        for (int k = 0; k < 254; k++) tick();
        chk("l255_q", int'(bus.Q), 1);
        tick();
        chk("l255_done", int'({bus.Q, bus.Done, bus.Expired}), 3);

        // Load on the terminal-count edge
        drive(1'b1, 8'd2, 1'b1, 1'b0);
        tick();
        bus.Load = 1'b0;
        tick();
        chk("tc_pre", int'(bus.Q), 1);
        drive(1'b1, 8'd7, 1'b1, 1'b0);
        tick();
        chk("tc_load_q", int'(bus.Q), 7);
        chk("tc_load_done", int'(bus.Done), 0);
        bus.Load = 1'b0;

        // Clear mid-count
        drive(1'b1, 8'd8, 1'b1, 1'b0);
        tick();
        bus.Load = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("clr_pre", int'(bus.Q), 4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_q", int'({bus.Q, bus.Busy, bus.Done}), 0);
        for (int k = 0; k < 6; k++) tick();
        chk("clr_ignore", int'({bus.Q, bus.Busy, bus.Done, bus.Expired}), 0);

        // Random phase against the model
        for (int k = 0; k < 3000; k++) begin
            clr = ($urandom_range(0, 199) == 0);
            bus.Load = ($urandom_range(0, 24) == 0);
            bus.Data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                   : 8'($urandom_range(0, 40));
            bus.Enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) bus.Reload = ~bus.Reload;
            tick();
        end

        @(negedge clk);
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
